m_ext_scheduler: RTL and testbench

Sequencer for the RV32M execution resources: accepts one M-extension operation from the multi-cycle core control FSM and dispatches it to the multiplier or the divider unit. It holds that unit's valid/op/operand lines until the unit reports completion, then returns a registered 32-bit result with a one-cycle done strobe. Only one operation is in flight at a time. It sits between the main control unit and the multiplier/divider datapaths and replaces ad-hoc valid generation in the core FSM.

---
 rtl/m_ext_pkg.sv | 68 ++++++
 rtl/m_ext_scheduler_if.sv | 48 ++++
 rtl/m_ext_fastpath.sv | 45 ++++
 rtl/m_ext_scheduler.sv | 144 ++++++++++++++
 tb/tb_m_ext_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_pkg
// Description : Shared types and constants for the RV32M scheduler slice:
//               FSM state type, unit op-code widths/codes, funct3 constants
//               and funct3-to-op-code decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package m_ext_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } m_ext_state_t;

    localparam int MUL_OP_WIDTH = 2;
    localparam int DIV_OP_WIDTH = 2;

    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH   = 2'd1;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHSU = 2'd2;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHU  = 2'd3;

    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct3[2] selects the divider
    localparam int F3_DIV_SEL_BIT = 2;

    function automatic logic [MUL_OP_WIDTH-1:0] mul_op_decode(input logic [2:0] f3);
        logic [MUL_OP_WIDTH-1:0] op;
        case (f3)
            F3_MUL:    op = MUL_OP_MUL;
            F3_MULH:   op = MUL_OP_MULH;
            F3_MULHSU: op = MUL_OP_MULHSU;
            F3_MULHU:  op = MUL_OP_MULHU;
            default:   op = MUL_OP_MUL;
        endcase
        return op;
    endfunction

    function automatic logic [DIV_OP_WIDTH-1:0] div_op_decode(input logic [2:0] f3);
        logic [DIV_OP_WIDTH-1:0] op;
        case (f3)
            F3_DIV:  op = DIV_OP_DIV;
            F3_DIVU: op = DIV_OP_DIVU;
            F3_REM:  op = DIV_OP_REM;
            F3_REMU: op = DIV_OP_REMU;
            default: op = DIV_OP_DIV;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_ext_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_scheduler_if
// Description : Request, multiplier, divider and result signals of the RV32M
//               scheduler. The slave modport is the scheduler's view; the
//               master modport is the view of the core FSM and the units.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_ext_scheduler_if
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_funct3;
    logic [XLEN-1:0]         req_rs1;
    logic [XLEN-1:0]         req_rs2;
    logic                    flush;
    logic                    mul_valid;
    logic [MUL_OP_WIDTH-1:0] MULop;
    logic                    mul_ready;
    logic [XLEN-1:0]         mul_result;
    logic                    div_valid;
    logic [DIV_OP_WIDTH-1:0] DIVop;
    logic                    div_ready;
    logic [XLEN-1:0]         div_result;
    logic [XLEN-1:0]         op_a;
    logic [XLEN-1:0]         op_b;
    logic                    done;
    logic [XLEN-1:0]         result;

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, flush,
        input  mul_ready, mul_result, div_ready, div_result,
        output req_ready, mul_valid, MULop, div_valid, DIVop,
        output op_a, op_b, done, result
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, flush,
        output mul_ready, mul_result, div_ready, div_result,
        input  req_ready, mul_valid, MULop, div_valid, DIVop,
        input  op_a, op_b, done, result
    );

endinterface
`default_nettype wire

// File: rtl/m_ext_fastpath.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_fastpath
// Description : Combinational detector for RV32M division special cases
//               (divide by zero, signed overflow) and their architectural
//               results, so they can complete without the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ext_fastpath
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [DIV_OP_WIDTH-1:0] div_op,
    input  wire logic [XLEN-1:0]         rs1,
    input  wire logic [XLEN-1:0]         rs2,
    output logic                         hit,
    output logic [XLEN-1:0]              value
);
    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic w_is_rem;
    logic w_is_signed;
    logic w_div_zero;
    logic w_overflow;

    assign w_is_rem    = (div_op == DIV_OP_REM) || (div_op == DIV_OP_REMU);
    assign w_is_signed = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
    assign w_div_zero  = (rs2 == '0);
    assign w_overflow  = w_is_signed && (rs1 == C_MIN_NEG) && (rs2 == '1);

    // Quotient of a zero divide is all ones, remainder is the dividend;
    // overflow quotient is the dividend itself, remainder is zero.
    always_comb begin
        hit   = w_div_zero || w_overflow;
        value = '0;
        if (w_div_zero) begin
            value = w_is_rem ? rs1 : '1;
        end else if (w_overflow) begin
            value = w_is_rem ? '0 : rs1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_ext_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_scheduler
// Description : Accepts one RV32M operation at a time, dispatches it to the
//               multiplier or divider, holds valid/op/operands until the unit
//               completes, and returns a registered result with a one-cycle
//               done strobe. Optional macro M_EXT_DIV_FASTPATH_EN lets
//               division special cases complete without the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ext_scheduler
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    m_ext_scheduler_if.slave    bus
);
    m_ext_state_t            r_state;
    logic                    r_req_ready;
    logic                    r_mul_valid;
    logic                    r_div_valid;
    logic                    r_done;
    logic [XLEN-1:0]         r_result;
    logic [XLEN-1:0]         r_op_a;
    logic [XLEN-1:0]         r_op_b;
    logic [MUL_OP_WIDTH-1:0] r_mul_op;
    logic [DIV_OP_WIDTH-1:0] r_div_op;

    logic [MUL_OP_WIDTH-1:0] w_mul_op;
    logic [DIV_OP_WIDTH-1:0] w_div_op;
    logic                    w_is_div;
    logic                    w_fast_hit;
    logic [XLEN-1:0]         w_fast_value;

    assign w_mul_op = mul_op_decode(bus.req_funct3);
    assign w_div_op = div_op_decode(bus.req_funct3);
    assign w_is_div = bus.req_funct3[F3_DIV_SEL_BIT];

`ifdef M_EXT_DIV_FASTPATH_EN
    m_ext_fastpath #(
        .XLEN (XLEN)
    ) u_fastpath (
        .div_op (w_div_op),
        .rs1    (bus.req_rs1),
        .rs2    (bus.req_rs2),
        .hit    (w_fast_hit),
        .value  (w_fast_value)
    );
`else
    assign w_fast_hit   = 1'b0;
    assign w_fast_value = '0;
`endif

    // Control FSM with all outputs registered; async reset drops unit valids at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_mul_op    <= '0;
            r_div_op    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // flush is irrelevant here: an accept in IDLE always proceeds
                    if (bus.req_valid) begin
                        r_op_a      <= bus.req_rs1;
                        r_op_b      <= bus.req_rs2;
                        r_req_ready <= 1'b0;
                        if (!w_is_div) begin
                            r_mul_op    <= w_mul_op;
                            r_mul_valid <= 1'b1;
                            r_state     <= ST_MUL_WAIT;
                        end else if (w_fast_hit) begin
                            r_div_op <= w_div_op;
                            r_result <= w_fast_value;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_div_op    <= w_div_op;
                            r_div_valid <= 1'b1;
                            r_state     <= ST_DIV_WAIT;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    // flush takes priority over a simultaneous completion
                    if (bus.flush) begin
                        r_mul_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (bus.mul_ready) begin
                        r_result    <= bus.mul_result;
                        r_mul_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DIV_WAIT: begin
                    if (bus.flush) begin
                        r_div_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (bus.div_ready) begin
                        r_result    <= bus.div_result;
                        r_div_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mul_valid <= 1'b0;
                    r_div_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mul_valid = r_mul_valid;
    assign bus.div_valid = r_div_valid;
    assign bus.MULop     = r_mul_op;
    assign bus.DIVop     = r_div_op;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.done      = r_done;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_m_ext_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_ext_scheduler
// Description : Self-checking bench for m_ext_scheduler. Acts as the core FSM
//               and both execution units; expected results come from an
//               RV32M arithmetic reference. Honors M_EXT_DIV_FASTPATH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_ext_scheduler;
    import m_ext_pkg::*;

`ifdef M_EXT_DIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] model_result;

    m_ext_scheduler_if #(.XLEN(32)) bus ();

    m_ext_scheduler #(
        .XLEN (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RV32M architectural result from plain arithmetic
    function automatic logic [31:0] rv_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (f3)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); r = sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] exp_op_code(input logic [2:0] f3);
        logic [1:0] c;
        case (f3)
            3'd0: c = MUL_OP_MUL;
            3'd1: c = MUL_OP_MULH;
            3'd2: c = MUL_OP_MULHSU;
            3'd3: c = MUL_OP_MULHU;
            3'd4: c = DIV_OP_DIV;
            3'd5: c = DIV_OP_DIVU;
            3'd6: c = DIV_OP_REM;
            default: c = DIV_OP_REMU;
        endcase
        return c;
    endfunction

    // One complete transaction: accept, unit response after lat cycles, completion
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] unit_val,
                         input bit flush_at_ready, input bit flush_at_accept, input bit flush_in_done);
        bit          is_div;
        bit          special;
        bit          fast;
        logic [31:0] expv;
        is_div  = f3[2];
        special = is_div && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        fast    = FAST_EN && special;
        expv    = fast ? rv_m(f3, a, b) : unit_val;

        check("ready_before_accept", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.flush      = flush_at_accept;
        step();
        bus.req_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.req_funct3 = 3'($urandom);
        bus.req_rs1    = $urandom;
        bus.req_rs2    = $urandom;
        check("ready_after_accept", bus.req_ready, 0);

        if (fast) begin
            check("fast_done", bus.done, 1);
            check("fast_result", bus.result, expv);
            check("fast_div_valid", bus.div_valid, 0);
            check("fast_mul_valid", bus.mul_valid, 0);
            bus.flush = flush_in_done;
            step();
            bus.flush = 1'b0;
            check("fast_done_drop", bus.done, 0);
            check("fast_ready_back", bus.req_ready, 1);
            check("fast_result_hold", bus.result, expv);
            model_result = expv;
            return;
        end

        check("op_a", bus.op_a, a);
        check("op_b", bus.op_b, b);
        if (is_div) check("div_op", bus.DIVop, exp_op_code(f3));
        else        check("mul_op", bus.MULop, exp_op_code(f3));

        for (int i = 1; i <= lat; i++) begin
            check("mul_valid_hold", bus.mul_valid, !is_div);
            check("div_valid_hold", bus.div_valid, is_div);
            check("no_done_wait", bus.done, 0);
            if (i == lat) begin
                if (is_div) begin bus.div_ready = 1'b1; bus.div_result = unit_val; end
                else        begin bus.mul_ready = 1'b1; bus.mul_result = unit_val; end
                bus.flush = flush_at_ready;
            end else if ($urandom_range(0, 2) == 0) begin
                // stray pulse from the unit that is not in use
                if (is_div) begin bus.mul_ready = 1'b1; bus.mul_result = $urandom; end
                else        begin bus.div_ready = 1'b1; bus.div_result = $urandom; end
            end
            step();
            bus.mul_ready = 1'b0;
            bus.div_ready = 1'b0;
            bus.flush     = 1'b0;
        end

        if (flush_at_ready) begin
            check("flush_no_done", bus.done, 0);
            check("flush_mul_valid", bus.mul_valid, 0);
            check("flush_div_valid", bus.div_valid, 0);
            check("flush_ready", bus.req_ready, 1);
            check("flush_result_kept", bus.result, model_result);
            return;
        end

        check("done", bus.done, 1);
        check("result", bus.result, expv);
        check("valids_low_done", {bus.mul_valid, bus.div_valid}, 0);
        check("ready_low_done", bus.req_ready, 0);
        bus.flush = flush_in_done;
        step();
        bus.flush = 1'b0;
        check("done_one_cycle", bus.done, 0);
        check("ready_after_done", bus.req_ready, 1);
        check("result_hold", bus.result, expv);
        model_result = expv;
    endtask

    // Idle cycles with stray unit pulses that must be ignored
    task automatic idle_stray(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.mul_ready  = ($urandom_range(0, 1) == 0);
            bus.div_ready  = ($urandom_range(0, 1) == 0);
            bus.mul_result = $urandom;
            bus.div_result = $urandom;
            step();
            bus.mul_ready = 1'b0;
            bus.div_ready = 1'b0;
            check("idle_no_done", bus.done, 0);
            check("idle_result", bus.result, model_result);
            check("idle_valids", {bus.mul_valid, bus.div_valid}, 0);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        n_checks       = 0;
        n_errors       = 0;
        model_result   = '0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.flush      = 1'b0;
        bus.mul_ready  = 1'b0;
        bus.mul_result = '0;
        bus.div_ready  = 1'b0;
        bus.div_result = '0;
        rst            = 1'b1;
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mul_valid", bus.mul_valid, 0);
        check("rst_div_valid", bus.div_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_ops", {bus.op_a, bus.op_b}, 0);
        check("rst_codes", {bus.MULop, bus.DIVop}, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Directed cases
        do_op(3'd0, 32'd7, 32'd6, 3, 32'd42, 0, 0, 0);
        do_op(3'd5, 32'd100, 32'd7, 2, 32'd14, 0, 0, 0);
        do_op(3'd4, 32'd50, 32'd5, 2, 32'd10, 1, 0, 0);
        do_op(3'd1, 32'hFFFF_FFF0, 32'd3, 1, rv_m(3'd1, 32'hFFFF_FFF0, 32'd3), 0, 0, 0);
        do_op(3'd4, 32'd9, 32'd0, 2, rv_m(3'd4, 32'd9, 32'd0), 0, 0, 0);
        do_op(3'd6, 32'd5, 32'd0, 2, rv_m(3'd6, 32'd5, 32'd0), 0, 0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 0, 0, 0);
        do_op(3'd2, 32'd123, 32'd456, 1, rv_m(3'd2, 32'd123, 32'd456), 0, 1, 1);
        idle_stray(3);

        // Async reset in MUL_WAIT, checked before any clock edge
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'd3;
        bus.req_rs1    = 32'h1234;
        bus.req_rs2    = 32'h5678;
        step();
        bus.req_valid  = 1'b0;
        check("pre_rst_mul_valid", bus.mul_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mul_valid", bus.mul_valid, 0);
        check("arst_req_ready", bus.req_ready, 1);
        check("arst_result", bus.result, 0);
        check("arst_op_a", bus.op_a, 0);
        check("arst_mulop", bus.MULop, 0);
        step();
        rst = 1'b0;
        model_result = '0;
        bus.mul_ready  = 1'b1;
        bus.mul_result = 32'hDEAD_BEEF;
        step();
        bus.mul_ready = 1'b0;
        check("stray_after_rst_done", bus.done, 0);
        check("stray_after_rst_result", bus.result, 0);
        idle_stray(2);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            f3  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 2) b = 32'h0;
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) b = 32'($urandom_range(1, 15));
            do_op(f3, a, b, $urandom_range(1, 5), rv_m(f3, a, b),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) idle_stray($urandom_range(1, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
